// File: rtl/pc_seq_unit.sv
// pc_seq_unit: parametrised program counter with load, increment, signed
// relative add and a call/return stack of saved return addresses.
// One operation per cycle, priority ret > call > ld > rel > inc > hold.
// Optional build macro PC_SEQ_SAT_EN: inc, rel and the call push value
// saturate instead of wrapping modulo 2^WIDTH.
module pc_seq_unit #(
    parameter int               WIDTH       = 16,
    parameter int               STACK_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int               INC_STEP    = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ld,
    input  logic                               inc,
    input  logic                               rel,
    input  logic                               call,
    input  logic                               ret,
    input  logic [WIDTH-1:0]                   d,
    output logic [WIDTH-1:0]                   q,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_level,
    output logic                               stk_full,
    output logic                               stk_empty,
    output logic                               stk_err
);

    localparam int               SPW   = $clog2(STACK_DEPTH + 1);
    localparam int               IDXW  = $clog2(STACK_DEPTH);
    localparam logic [WIDTH-1:0] STEP  = WIDTH'(INC_STEP);
    localparam logic [SPW-1:0]   DEPTH = SPW'(STACK_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    logic [WIDTH-1:0] inc_val;   // q + INC_STEP, also the call return address
    logic [WIDTH-1:0] rel_val;   // q + d
    logic [WIDTH-1:0] top_entry;
    logic [IDXW-1:0]  push_idx, pop_idx;
    logic             push_en;
    logic             full, empty;

`ifdef PC_SEQ_SAT_EN
    logic [WIDTH:0] inc_sum, rel_sum;

    assign inc_sum = {1'b0, pc_q} + {1'b0, STEP};
    assign rel_sum = {1'b0, pc_q} + {1'b0, d};
    assign inc_val = inc_sum[WIDTH] ? '1 : inc_sum[WIDTH-1:0];
    // Positive offset: carry-out means overflow. Negative offset: the absence
    // of carry-out means the result went below zero.
    assign rel_val = (d[WIDTH-1] == 1'b0)
                   ? (rel_sum[WIDTH] ? '1 : rel_sum[WIDTH-1:0])
                   : (rel_sum[WIDTH] ? rel_sum[WIDTH-1:0] : '0);
`else
    assign inc_val = pc_q + STEP;
    assign rel_val = pc_q + d;
`endif

    assign full      = (sp_q == DEPTH);
    assign empty     = (sp_q == '0);
    assign push_idx  = IDXW'(sp_q);
    assign pop_idx   = IDXW'(sp_q - SPW'(1));
    assign top_entry = stack_q[pop_idx];

    // Next-state selection by command priority; errors only set, never clear.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (ret) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                pc_d = top_entry;
                sp_d = sp_q - SPW'(1);
            end
        end else if (call) begin
            if (full) begin
                err_d = 1'b1;
            end else begin
                push_en = 1'b1;
                sp_d    = sp_q + SPW'(1);
                pc_d    = d;
            end
        end else if (ld) begin
            pc_d = d;
        end else if (rel) begin
            pc_d = rel_val;
        end else if (inc) begin
            pc_d = inc_val;
        end
    end

    // State registers and return-address stack.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            pc_q  <= RESET_VAL;
            sp_q  <= '0;
            err_q <= 1'b0;
            // NOTE: stack entries are reset too, so no slot ever holds X.
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
            if (push_en) begin
                stack_q[push_idx] <= inc_val;
            end
        end
    end

    assign q         = pc_q;
    assign sp_level  = sp_q;
    assign stk_full  = full;
    assign stk_empty = empty;
    assign stk_err   = err_q;

endmodule
